// File: rtl/gpio_pkg.sv
// gpio_pkg -- shared widths and FSM state type for the GPIO input conditioner.
package gpio_pkg;

    localparam int SW_WIDTH   = 18;  // board switch count
    localparam int GPIO_WIDTH = 32;  // CPU GPIO input word
    localparam int CNT_WIDTH  = 16;  // debounce counter width

    // Debounce FSM: IDLE while the sample matches the committed word,
    // COUNT while a different candidate word is being qualified.
    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

endpackage : gpio_pkg

// File: rtl/gpio_in_conditioner_sync_chain.sv
// sync_chain -- STAGES-deep flop chain that brings an asynchronous bus into
// the clk domain. No logic may be placed between the stages.
module sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    // Shift the raw level one stage deeper on every clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make each stage take its
            // predecessor's old value; blocking ones would collapse the
            // chain into a single flop.
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule : sync_chain

// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner -- synchronizes and debounces the 18 board switches
// into a 32-bit GPIO input word. A new switch word is committed atomically
// only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
// Optional feature macro: GPIO_IN_CHANGE_EN adds a sticky chg_flag that
// sets on every commit that changes the word and is cleared by chg_ack.
// Legal parameters: SYNC_STAGES 2..4, DEBOUNCE_CYCLES 2..65535.
module gpio_in_conditioner
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SW_WIDTH-1:0]   sw_raw,
    output logic [GPIO_WIDTH-1:0] GPIO_in
`ifdef GPIO_IN_CHANGE_EN
    ,
    output logic                  chg_flag,
    input  logic                  chg_ack
`endif
);

    localparam logic [CNT_WIDTH-1:0] CNT_DONE = CNT_WIDTH'(DEBOUNCE_CYCLES);

    logic [SW_WIDTH-1:0]  s;          // synchronized sample
    logic [SW_WIDTH-1:0]  candidate;  // word being qualified
    logic [SW_WIDTH-1:0]  stable;     // committed word
    logic [CNT_WIDTH-1:0] cnt;        // identical samples seen so far
    state_t               state;
    logic                 commit;

    sync_chain #(
        .WIDTH  (SW_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sw_raw),
        .q   (s)
    );

    // The candidate has been seen DEBOUNCE_CYCLES times and is still present.
    assign commit = (state == COUNT) && (s == candidate) && (cnt == CNT_DONE);

    // Debounce FSM: qualify a candidate word, then commit it as one word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            candidate <= '0;
            stable    <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s != stable) begin
                        candidate <= s;
                        cnt       <= CNT_WIDTH'(1);
                        state     <= COUNT;
                    end else begin
                        cnt <= '0;
                    end
                end
                COUNT: begin
                    if (s == candidate) begin
                        if (commit) begin
                            stable <= candidate;
                            cnt    <= '0;
                            state  <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (s == stable) begin
                        // Bounce died out before qualifying: drop it.
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        // A different new word: restart qualification on it.
                        candidate <= s;
                        cnt       <= CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign GPIO_in = {{(GPIO_WIDTH - SW_WIDTH){1'b0}}, stable};

`ifdef GPIO_IN_CHANGE_EN
    // Sticky change flag: a changing commit wins over a coincident ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chg_flag <= 1'b0;
        end else if (commit && (candidate != stable)) begin
            chg_flag <= 1'b1;
        end else if (chg_ack) begin
            chg_flag <= 1'b0;
        end
    end
`endif

endmodule : gpio_in_conditioner
